// File: rtl/sync_fifo_gen.sv
// Parametrised single-clock FIFO with programmable thresholds, flush and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads via a prefetch register.
module sync_fifo_gen #(
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned DEPTH_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_full,
  output logic                   almost_full,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_empty,
  output logic                   almost_empty,
  input  logic [DEPTH_WIDTH:0]   af_thresh,
  input  logic [DEPTH_WIDTH:0]   ae_thresh,
  output logic [DEPTH_WIDTH:0]   level,
  input  logic                   flush,
  input  logic                   err_clr,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned Depth = 2 ** DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] LvlFull = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH:0] LvlOne  = (DEPTH_WIDTH + 1)'(1);
  localparam logic [DEPTH_WIDTH-1:0] PtrOne = DEPTH_WIDTH'(1);

  logic [DATA_WIDTH-1:0]  mem [Depth];
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]   level_q, level_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic                   wr_acc, rd_acc, mem_we, ram_rd;

`ifdef SYNC_FIFO_FWFT_EN
  logic                   head_valid_q, head_valid_d;
  logic [DEPTH_WIDTH:0]   ram_cnt;

  // The prefetch register holds one counted word, so the RAM holds level minus that.
  assign ram_cnt  = level_q - {{DEPTH_WIDTH{1'b0}}, head_valid_q};
  assign rd_empty = ~head_valid_q;
`else
  assign rd_empty = (level_q == '0);
`endif

  assign wr_full      = (level_q == LvlFull);
  assign almost_full  = (level_q >= af_thresh);
  assign almost_empty = (level_q <= ae_thresh);
  assign level        = level_q;
  assign rd_data      = rd_data_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wr_acc      = wr_en & ~wr_full;
    rd_acc      = rd_en & ~rd_empty;
    mem_we      = wr_acc & ~flush;
    ram_rd      = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rd_data_d   = rd_data_q;
`ifdef SYNC_FIFO_FWFT_EN
    head_valid_d = head_valid_q;
`endif

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
`ifdef SYNC_FIFO_FWFT_EN
      head_valid_d = 1'b0;
`endif
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PtrOne;
      end
`ifdef SYNC_FIFO_FWFT_EN
      // Refill the head whenever it is empty or being popped this cycle.
      ram_rd = (ram_cnt != '0) & (~head_valid_q | rd_acc);
      if (ram_rd) begin
        head_valid_d = 1'b1;
      end else if (rd_acc) begin
        head_valid_d = 1'b0;
      end
`else
      ram_rd = rd_acc;
`endif
      if (ram_rd) begin
        rd_ptr_d  = rd_ptr_q + PtrOne;
        rd_data_d = mem[rd_ptr_q];
      end
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LvlOne;
        2'b01:   level_d = level_q - LvlOne;
        default: level_d = level_q;
      endcase
    end

    // Set wins over clear; flush suppresses error events as it suppresses the transfer.
    overflow_d  = (overflow_q & ~err_clr) | (wr_en & wr_full & ~flush);
    underflow_d = (underflow_q & ~err_clr) | (rd_en & rd_empty & ~flush);
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid_q <= 1'b0;
    end else begin
      head_valid_q <= head_valid_d;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_gen.sv
// Self-checking bench for sync_fifo_gen (DEPTH_WIDTH=4): table vectors, a queue model and
// a read scoreboard; a separate sequence runs when built with SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_gen;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en, flush, err_clr;
  logic [DW-1:0] wr_data, rd_data;
  logic          wr_full, almost_full, rd_empty, almost_empty, overflow, underflow;
  logic [AW:0]   af_thresh, ae_thresh, level;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_rd;
  logic          m_ovf, m_unf;

  typedef struct {
    logic          wr;
    logic [DW-1:0] wd;
    logic          rd;
    logic          fl;
    logic          ec;
    int            lvl;
    logic          unf;
  } vec_t;
  vec_t vt[8];

  always #5 clk = ~clk;

  sync_fifo_gen #(
    .DATA_WIDTH (DW),
    .DEPTH_WIDTH(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_full     (wr_full),
    .almost_full (almost_full),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_empty    (rd_empty),
    .almost_empty(almost_empty),
    .af_thresh   (af_thresh),
    .ae_thresh   (ae_thresh),
    .level       (level),
    .flush       (flush),
    .err_clr     (err_clr),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(rd_empty), 32'd1);
    chk("rst_full", 32'(wr_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_afull", 32'(almost_full), 32'(af_thresh == '0));
    rst = 1'b0;
    mq.delete(); exp_q.delete();
    m_rd = '0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  // One cycle of standard-mode stimulus, model update and post-edge checking.
  task automatic drive(input logic w, input logic [DW-1:0] d, input logic r, input logic f,
                       input logic e);
    logic m_full, m_empty, wa, ra;
    wr_en = w; wr_data = d; rd_en = r; flush = f; err_clr = e;
    m_full  = (mq.size() == DEPTH);
    m_empty = (mq.size() == 0);
    wa = w && !m_full && !f;
    ra = r && !m_empty && !f;
    m_ovf = (m_ovf && !e) || (w && m_full && !f);
    m_unf = (m_unf && !e) || (r && m_empty && !f);
    if (ra) begin
      m_rd = mq.pop_front();
      exp_q.push_back(m_rd);
    end
    if (wa) mq.push_back(d);
    if (f) mq.delete();
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    if (ra) chk("rd_pop", 32'(rd_data), 32'(exp_q.pop_front()));
    else    chk("rd_hold", 32'(rd_data), 32'(m_rd));
    chk("level", 32'(level), 32'(mq.size()));
    chk("rd_empty", 32'(rd_empty), 32'(mq.size() == 0));
    chk("wr_full", 32'(wr_full), 32'(mq.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= int'(af_thresh)));
    chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= int'(ae_thresh)));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    af_thresh = 5'd12;
    ae_thresh = 5'd3;
    do_reset();
    af_thresh = '0;
    #1;
    chk("afull_thresh0", 32'(almost_full), 32'd1);
    af_thresh = 5'd12;
    #1;

`ifdef SYNC_FIFO_FWFT_EN
    begin
      logic [DW-1:0] fq[$];
      wr_en = 1'b1; wr_data = 16'h42;
      @(posedge clk); #1;
      wr_en = 1'b0;
      chk("fwft_empty_n", 32'(rd_empty), 32'd1);
      chk("fwft_level_n", 32'(level), 32'd1);
      @(posedge clk); #1;
      chk("fwft_empty_n1", 32'(rd_empty), 32'd0);
      chk("fwft_head", 32'(rd_data), 32'h42);
      rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
      chk("fwft_empty_pop", 32'(rd_empty), 32'd1);
      chk("fwft_level_pop", 32'(level), 32'd0);
      for (int i = 0; i < 5; i++) begin
        wr_en = 1'b1; wr_data = DW'(i * 3 + 1); fq.push_back(DW'(i * 3 + 1));
        @(posedge clk); #1;
      end
      wr_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
        chk("fwft_level", 32'(level), 32'(5 - i));
        chk("fwft_nempty", 32'(rd_empty), 32'd0);
        chk("fwft_data", 32'(rd_data), 32'(fq.pop_front()));
        rd_en = 1'b1;
        @(posedge clk); #1;
      end
      rd_en = 1'b0;
      chk("fwft_drained", 32'(rd_empty), 32'd1);
      chk("fwft_unf0", 32'(underflow), 32'd0);
      rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
      chk("fwft_unf1", 32'(underflow), 32'd1);
    end
`else
    // Fill/drain
    for (int i = 0; i < 16; i++) drive(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_full", 32'(wr_full), 32'd1);
    chk("fill_level", 32'(level), 32'd16);
    for (int i = 0; i < 16; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("drain_empty", 32'(rd_empty), 32'd1);
    chk("drain_last", 32'(rd_data), 32'd15);

    // Underflow / err_clr table, starting empty with flags clear
    vt[0] = '{wr: 1'b1, wd: 16'h55, rd: 1'b1, fl: 1'b0, ec: 1'b0, lvl: 1, unf: 1'b1};
    vt[1] = '{wr: 1'b0, wd: 16'h00, rd: 1'b1, fl: 1'b0, ec: 1'b0, lvl: 0, unf: 1'b1};
    vt[2] = '{wr: 1'b0, wd: 16'h00, rd: 1'b0, fl: 1'b0, ec: 1'b1, lvl: 0, unf: 1'b0};
    vt[3] = '{wr: 1'b1, wd: 16'h01, rd: 1'b0, fl: 1'b0, ec: 1'b0, lvl: 1, unf: 1'b0};
    vt[4] = '{wr: 1'b1, wd: 16'h02, rd: 1'b0, fl: 1'b0, ec: 1'b0, lvl: 2, unf: 1'b0};
    vt[5] = '{wr: 1'b1, wd: 16'h03, rd: 1'b1, fl: 1'b0, ec: 1'b0, lvl: 2, unf: 1'b0};
    vt[6] = '{wr: 1'b0, wd: 16'h00, rd: 1'b0, fl: 1'b1, ec: 1'b0, lvl: 0, unf: 1'b0};
    vt[7] = '{wr: 1'b0, wd: 16'h00, rd: 1'b1, fl: 1'b0, ec: 1'b1, lvl: 0, unf: 1'b1};
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].wr, vt[i].wd, vt[i].rd, vt[i].fl, vt[i].ec);
      chk("vec_level", 32'(level), 32'(vt[i].lvl));
      chk("vec_unf", 32'(underflow), 32'(vt[i].unf));
      if (i == 0) chk("vec_unf_rd_hold", 32'(rd_data), 32'd15);
      if (i == 1) chk("vec_no_bypass", 32'(rd_data), 32'h55);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Overflow: read rescues nothing
    for (int i = 0; i < 16; i++) drive(1'b1, DW'(16'h100 + i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'hAA, 1'b1, 1'b0, 1'b0);
    chk("ovf_rd", 32'(rd_data), 32'h100);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd15);
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      if (rd_data == 16'hAA) chk("ovf_dropped", 32'(rd_data), 32'(16'h101 + i));
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Thresholds
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, DW'(16'h200 + i), 1'b0, 1'b0, 1'b0);
      if (i == 3) chk("ae_fall_at4", 32'(almost_empty), 32'd0);
      if (i == 10) chk("af_low_at11", 32'(almost_full), 32'd0);
    end
    chk("af_rise_at12", 32'(almost_full), 32'd1);
    af_thresh = 5'd13;
    #1;
    chk("af_thresh_change", 32'(almost_full), 32'd0);
    ae_thresh = 5'd12;
    #1;
    chk("ae_thresh_change", 32'(almost_empty), 32'd1);
    ae_thresh = 5'd3;

    // Flush with 7 words held beats simultaneous write and read
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("pre_flush_level", 32'(level), 32'd7);
    drive(1'b1, 16'h99, 1'b1, 1'b1, 1'b0);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_empty", 32'(rd_empty), 32'd1);
    chk("flush_rd_hold", 32'(rd_data), 32'h204);
    drive(1'b1, 16'h11, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("flush_then_rd", 32'(rd_data), 32'h11);

    // Sustained simultaneous write and read at constant level
    for (int i = 0; i < 8; i++) drive(1'b1, DW'(16'h300 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, DW'(16'h400 + i), 1'b1, 1'b0, 1'b0);
    chk("thru_level", 32'(level), 32'd8);
    for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("thru_last", 32'(rd_data), 32'h413);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_gen.md
# sync_fifo_gen

Parametrised single-clock FIFO for the DDR3 controller datapath, used wherever buffering is needed in a single clock domain, such as write-data staging ahead of the AXI/DDR write path. Generalises the fixed 256x256 write FIFO:
- any data width and power-of-two depth;
- runtime-programmable almost-full/almost-empty thresholds;
- exact occupancy output;
- synchronous flush;
- sticky overflow/underflow error flags;
- optional first-word-fall-through read mode.

## Interface
Parameters:
- DATA_WIDTH, 256, width of a word, 1..1152
- DEPTH_WIDTH, 8, log2 of depth; DEPTH = 2**DEPTH_WIDTH words, 2..16

Ports:
- clk  in  1  single clock for write and read
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- wr_full  out  1  FIFO holds DEPTH words
- almost_full  out  1  level >= af_thresh
- rd_en  in  1  read/pop request
- rd_data  out  DATA_WIDTH  read word
- rd_empty  out  1  no word available to read
- almost_empty  out  1  level <= ae_thresh
- af_thresh  in  DEPTH_WIDTH+1  almost-full threshold, quasi-static
- ae_thresh  in  DEPTH_WIDTH+1  almost-empty threshold, quasi-static
- level  out  DEPTH_WIDTH+1  current occupancy, 0..DEPTH
- flush  in  1  synchronous discard of all contents
- err_clr  in  1  clears sticky error flags
- overflow  out  1  sticky: write attempted while wr_full
- underflow  out  1  sticky: read attempted while rd_empty

## Operation
- Storage is DEPTH x DATA_WIDTH simple dual-port RAM with registered read. Write and read pointers are DEPTH_WIDTH bits and wrap naturally modulo DEPTH.
- Accepted write = wr_en & !wr_full. Accepted read = rd_en & !rd_empty. Both use the flag values sampled in the same cycle.
- Write while wr_full: word dropped, pointers unchanged, overflow set. A simultaneous accepted read does not rescue the write.
- Read while rd_empty: no pop, rd_data unchanged, underflow set. A simultaneous write does not bypass to the read side.
- level: +1 on an accepted write only, -1 on an accepted read only, unchanged when both or neither occur. Never exceeds DEPTH and never goes below 0.
- Flags are combinational from the registered level:
  - wr_full = (level == DEPTH)
  - rd_empty = (level == 0) in standard mode
  - almost_full = (level >= af_thresh)
  - almost_empty = (level <= ae_thresh)
- flush has priority over wr_en and rd_en in the same cycle. It zeroes the pointers and level, and leaves rd_data and the sticky flags unchanged.
- err_clr clears overflow and underflow. If an error event occurs in the same cycle, that event sets its flag (set wins).
- rst behaves as flush + err_clr, and also clears rd_data.
- Reset values: level=0, rd_empty=1, wr_full=0, overflow=0, underflow=0, rd_data=0. almost_empty=1 and almost_full=(af_thresh==0), both following the threshold equations.

## Timing
- Standard mode:
  - Write accepted at edge N: level and rd_empty update after edge N. The word is readable by an rd_en in cycle N+1.
  - Read accepted at edge N: rd_data presents the word after edge N, so it is valid in cycle N+1, and holds until the next accepted read.
  - Read latency is 1 cycle.
- Full throughput: one write and one read per cycle, sustained, with level constant.
- Threshold changes take effect in the same cycle, because the flag compares are combinational.
- Flush at edge N: from cycle N+1, rd_empty=1 and level=0.

## Configuration
- Macro SYNC_FIFO_FWFT_EN.
- Defined: first-word-fall-through mode.
  - rd_data shows the head word whenever rd_empty=0.
  - rd_en pops the head, and the next word appears in the following cycle.
  - An internal prefetch register is counted in level, so total capacity stays DEPTH.
  - After a write to an empty FIFO at edge N, rd_empty deasserts after edge N+1 (2-cycle latency); level updates after edge N as usual.
- Undefined: standard mode as above, with no prefetch logic.

## Test plan
- Fill/drain, DEPTH_WIDTH=4: write 0..15 with no reads. wr_full=1 and level=16. Then read 16 words: data 0..15 in order, rd_empty=1, and overflow and underflow both remain 0.
- Overflow: fill 16 words, then write 0xAA together with rd_en. The read returns word 0, overflow=1, level=15, and 0xAA never appears on a later read. Then err_clr: overflow=0.
- Underflow: on an empty FIFO, rd_en together with wr_en(0x55). underflow=1 and rd_data is unchanged. The next cycle's rd_en returns 0x55.
- Thresholds: af_thresh=12, ae_thresh=3. Write 12 words: almost_full rises exactly when level reaches 12 and almost_empty falls at level 4. Then change af_thresh to 13: almost_full drops in the same cycle.
- Flush: with 7 words held, assert flush together with wr_en and rd_en. Result: level=0, rd_empty=1, no pop, no write. Then write 0x11 and read 0x11 back.
- FWFT build: write 0x42 at edge N. rd_empty=0 after edge N+1 and rd_data=0x42 before any rd_en. Then rd_en: rd_empty=1.
